cla_group_seq_adder: RTL and testbench

- Multi-cycle carry-lookahead adder; consumes operands one GROUP-bit slice per clock.
- Per bit: the same s/p/g terms as the team's 1-bit CLA cell (p = a|b, g = a&b, s = a^b^c).
- Per slice: lookahead carries; the carry-out is registered and feeds the next slice.
- Sits downstream of the 1-bit cells as the carry/sequencing stage of the CLA datapath.
- Gives a start/busy/done handshake to the surrounding control logic.

---
 rtl/cla_group_seq_adder_if.sv | 25 ++
 rtl/cla_group_seq_adder.sv | 132 +++++++++++++
 tb/tb_cla_group_seq_adder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cla_group_seq_adder_if.sv
// Handshake and operand/result bundle for the sequential group carry-lookahead adder.
// The master drives requests and operands; the slave returns status and results.
interface cla_group_seq_adder_if #(
   parameter int WIDTH = 16
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/cla_group_seq_adder.sv
// Multi-cycle adder: one GROUP-bit lookahead slice per clock.
// The slice carry-out is registered and becomes the next slice's carry-in.
module cla_group_seq_adder #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   cla_group_seq_adder_if.slave  bus
);
   localparam int N     = WIDTH / GROUP;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q;
   logic [WIDTH-1:0]   a_q, b_q, psum_q, sum_q;
   logic               carry_q, cout_q, ovf_q, busy_q, done_q;
   logic               busy_d, done_d;

   logic               accept;
   logic               last_slice;
   logic [GROUP-1:0]   sa, sb, p, g, slice_sum;
   logic [GROUP:0]     c;
   logic               term, acc;

   assign accept     = bus.start && (state_q != CALC);
   assign last_slice = (idx_q == IDX_W'(N - 1));
   assign sa         = a_q[GROUP-1:0];
   assign sb         = b_q[GROUP-1:0];

   // Two-level lookahead: each carry is a flat sum of generate/propagate products.
   always_comb begin
      p    = sa | sb;
      g    = sa & sb;
      c    = '0;
      term = 1'b0;
      acc  = 1'b0;
      c[0] = carry_q;
      for (int i = 0; i < GROUP; i++) begin
         term = carry_q;
         for (int k = 0; k <= i; k++) begin
            term = term & p[k];
         end
         acc = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) begin
               term = term & p[k];
            end
            acc = acc | term;
         end
         c[i+1] = acc;
      end
      slice_sum = sa ^ sb ^ c[GROUP-1:0];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept ? CALC : IDLE;
         CALC:    state_d = last_slice ? DONE : CALC;
         DONE:    state_d = accept ? CALC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_d = (state_d == CALC);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Operands shift down one slice per cycle; the partial sum fills from the top.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         psum_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         idx_q   <= '0;
         a_q     <= bus.a;
         b_q     <= bus.b;
         carry_q <= bus.cin;
         psum_q  <= '0;
      end else if (state_q == CALC) begin
         idx_q   <= idx_q + IDX_W'(1);
         a_q     <= a_q >> GROUP;
         b_q     <= b_q >> GROUP;
         carry_q <= c[GROUP];
         psum_q  <= {slice_sum, psum_q[WIDTH-1:GROUP]};
         if (last_slice) begin
            sum_q  <= {slice_sum, psum_q[WIDTH-1:GROUP]};
            cout_q <= c[GROUP];
            ovf_q  <= c[GROUP] ^ c[GROUP-1];
         end else begin
            sum_q  <= sum_q;
            cout_q <= cout_q;
            ovf_q  <= ovf_q;
         end
      end else begin
         idx_q <= idx_q;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_cla_group_seq_adder.sv
// Scoreboard bench for cla_group_seq_adder (WIDTH=16, GROUP=4): expected results
// are queued when an accepted start is driven and checked when done pulses.
module tb_cla_group_seq_adder;
   localparam int WIDTH = 16;
   localparam int GROUP = 4;
   localparam int LAT   = WIDTH / GROUP + 1;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      int               cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_fail;
   exp_t exp_q[$];
   exp_t got_e;

   cla_group_seq_adder_if #(.WIDTH(WIDTH)) bus ();

   cla_group_seq_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic ci, input int at_cyc);
      exp_t        e;
      logic [WIDTH:0] full;
      full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
      e.sum  = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
      e.cyc  = at_cyc;
      return e;
   endfunction

   // Result scoreboard: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_done", 32'(bus.done), 32'd0);
         end else begin
            got_e = exp_q.pop_front();
            check_eq("sum", 32'(bus.sum), 32'(got_e.sum));
            check_eq("cout", 32'(bus.cout), 32'(got_e.cout));
            check_eq("ovf", 32'(bus.ovf), 32'(got_e.ovf));
            check_eq("done_cycle", 32'(cyc), 32'(got_e.cyc));
         end
      end
   end

   // Drive one start cycle from the current cycle; optionally queue its result.
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic ci, input bit expect_done);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = ci;
      if (expect_done) exp_q.push_back(model(a, b, ci, cyc + LAT));
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check_eq("drain_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_sum", 32'(bus.sum), 32'd0);
      check_eq("rst_cout", 32'(bus.cout), 32'd0);
      check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
      @(posedge clk); #1;

      start_op(16'h1234, 16'h4321, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         check_eq("busy_calc", 32'(bus.busy), 32'd1);
         @(posedge clk); #1;
      end
      check_eq("busy_done_cycle", 32'(bus.busy), 32'd0);
      drain();

      start_op(16'hFFFF, 16'h0000, 1'b1, 1'b1); drain();
      start_op(16'h00FF, 16'h0F01, 1'b0, 1'b1); drain();
      start_op(16'h7FFF, 16'h0001, 1'b0, 1'b1); drain();
      start_op(16'h8000, 16'h8000, 1'b0, 1'b1); drain();
      start_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1); drain();

      // start and operand changes while busy must not disturb the add in flight
      start_op(16'h1111, 16'h2222, 1'b0, 1'b1);
      start_op(16'hAAAA, 16'h5555, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         bus.a   = 16'($urandom);
         bus.b   = 16'($urandom);
         bus.cin = 1'($urandom);
         @(posedge clk); #1;
      end
      drain();

      // back-to-back: second start lands in the done cycle of the first
      start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
      repeat (4) begin
         @(posedge clk); #1;
      end
      check_eq("b2b_done_seen", 32'(bus.done), 32'd1);
      start_op(16'h0001, 16'h0001, 1'b0, 1'b1);
      drain();

      // reset mid-operation aborts without a done pulse
      start_op(16'h1357, 16'h2468, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("abort_busy", 32'(bus.busy), 32'd0);
      check_eq("abort_done", 32'(bus.done), 32'd0);
      check_eq("abort_sum", 32'(bus.sum), 32'd0);
      check_eq("abort_cout", 32'(bus.cout), 32'd0);
      rst = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
      end
      start_op(16'h0003, 16'h0004, 1'b0, 1'b1);
      drain();

      for (int i = 0; i < 10; i++) begin
         start_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
         drain();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
